// File: rtl/mon_bus_pkg.sv
// Shared types and bus constants for the monitor slot front end.
package mon_bus_pkg;
  localparam int DATA_W = 8;
  localparam logic [DATA_W-1:0] IDLE_BYTE = 8'hFF;

  typedef enum logic [1:0] {S_LOW, S_QHI, S_HIGH, S_QLO} mon_state_e;
endpackage

// File: rtl/mon_bus_sync.sv
// N-bit multi-flop synchroniser with a per-bit reset value.
module mon_bus_sync #(
  parameter int         SYNC_STAGES = 2,
  parameter int         N           = 1,
  parameter logic [N-1:0] RST_VAL   = '0
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [N-1:0] d_i,
  output logic [N-1:0] q_o
);
  logic [SYNC_STAGES-1:0][N-1:0] pipe_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) pipe_q <= {SYNC_STAGES{RST_VAL}};
    else         pipe_q <= {pipe_q[SYNC_STAGES-2:0], d_i};
  end

  assign q_o = pipe_q[SYNC_STAGES-1];
endmodule

// File: rtl/monitor_bus_frontend.sv
// Slot bus front end: synchronise, deglitch clk_rw into edge events, drive read data back.
// Optional watchdog on a stuck-high strobe is enabled with `define MON_BUS_TIMEOUT_EN.
module monitor_bus_frontend
  import mon_bus_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int QUAL_CYC    = 3,
  parameter int TIMEOUT_CYC = 2000000
) (
  input  logic              clk_20mhz,
  input  logic              reset_x,
  input  logic              slot_x,
  input  logic              clk_rw,
  input  logic              ax_d,
  input  logic              r_wx,
  input  logic [DATA_W-1:0] data_in,
  output logic              ev_valid,
  output logic              ev_rise,
  output logic              ev_ax_d,
  output logic              ev_r_wx,
  output logic [DATA_W-1:0] ev_data,
  input  logic [DATA_W-1:0] rd_data,
  input  logic              rd_load,
  input  logic              rd_oe,
  output logic [DATA_W-1:0] data_out,
  output logic              data_oe_x,
  output logic              bus_timeout
);
  localparam int            QW    = $clog2(QUAL_CYC + 1);
  localparam logic [QW-1:0] QLAST = QW'(QUAL_CYC - 1);

  if (SYNC_STAGES < 2 || QUAL_CYC < 2 || TIMEOUT_CYC < 1 || TIMEOUT_CYC > 2097151) begin : g_param_chk
    $error("monitor_bus_frontend: parameter out of range");
  end

  logic              s_slot_x, s_rw, s_ax_d, s_r_wx;
  logic [DATA_W-1:0] s_data;

  // slot_x resets to deselected so nothing is reported until the first real select
  mon_bus_sync #(.SYNC_STAGES(SYNC_STAGES), .N(4), .RST_VAL(4'b1000)) u_sync_ctl (
    .clk_i (clk_20mhz),
    .rst_ni(reset_x),
    .d_i   ({slot_x, clk_rw, ax_d, r_wx}),
    .q_o   ({s_slot_x, s_rw, s_ax_d, s_r_wx})
  );

  mon_bus_sync #(.SYNC_STAGES(SYNC_STAGES), .N(DATA_W), .RST_VAL(IDLE_BYTE)) u_sync_dat (
    .clk_i (clk_20mhz),
    .rst_ni(reset_x),
    .d_i   (data_in),
    .q_o   (s_data)
  );

  mon_state_e    state_q, state_d;
  logic [QW-1:0] qcnt_q, qcnt_d;
  logic          emit, tmo_hit;

  always_ff @(posedge clk_20mhz or negedge reset_x) begin
    if (!reset_x) begin
      state_q <= S_LOW;
      qcnt_q  <= '0;
    end else begin
      state_q <= tmo_hit ? S_LOW : state_d;
      qcnt_q  <= tmo_hit ? '0    : qcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    qcnt_d  = qcnt_q;
    emit    = 1'b0;
    unique case (state_q)
      S_LOW:  if (s_rw) begin state_d = S_QHI; qcnt_d = QW'(1); end
      S_QHI: begin
        if (!s_rw) begin
          state_d = S_LOW;
          qcnt_d  = '0;
        end else if (qcnt_q == QLAST) begin
          state_d = S_HIGH;
          qcnt_d  = '0;
          emit    = 1'b1;
        end else begin
          qcnt_d  = qcnt_q + 1'b1;
        end
      end
      S_HIGH: if (!s_rw) begin state_d = S_QLO; qcnt_d = QW'(1); end
      S_QLO: begin
        if (s_rw) begin
          state_d = S_HIGH;
          qcnt_d  = '0;
        end else if (qcnt_q == QLAST) begin
          state_d = S_LOW;
          qcnt_d  = '0;
          emit    = 1'b1;
        end else begin
          qcnt_d  = qcnt_q + 1'b1;
        end
      end
      default: begin state_d = S_LOW; qcnt_d = '0; end
    endcase
  end

  // The FSM keeps tracking while deselected; only the report is masked.
  logic              ev_valid_q, ev_rise_q, ev_ax_d_q, ev_r_wx_q;
  logic [DATA_W-1:0] ev_data_q;
  logic              report;

  assign report = emit & ~s_slot_x;

  always_ff @(posedge clk_20mhz or negedge reset_x) begin
    if (!reset_x) begin
      ev_valid_q <= 1'b0;
      ev_rise_q  <= 1'b0;
      ev_ax_d_q  <= 1'b0;
      ev_r_wx_q  <= 1'b0;
      ev_data_q  <= '0;
    end else begin
      ev_valid_q <= report;
      if (report) begin
        ev_rise_q <= (state_q == S_QHI);
        ev_ax_d_q <= s_ax_d;
        ev_r_wx_q <= s_r_wx;
        ev_data_q <= s_data;
      end
    end
  end

  assign ev_valid = ev_valid_q;
  assign ev_rise  = ev_rise_q;
  assign ev_ax_d  = ev_ax_d_q;
  assign ev_r_wx  = ev_r_wx_q;
  assign ev_data  = ev_data_q;

  logic [DATA_W-1:0] dout_q;
  logic              oe_x_q;

  always_ff @(posedge clk_20mhz or negedge reset_x) begin
    if (!reset_x) begin
      dout_q <= IDLE_BYTE;
      oe_x_q <= 1'b1;
    end else begin
      if (rd_load) dout_q <= rd_data;
      oe_x_q <= ~(rd_oe & s_ax_d & s_r_wx & ~s_slot_x);
    end
  end

  // Raw r_wx lets a write cycle release the bus without waiting for the synchroniser.
  assign data_out  = dout_q;
  assign data_oe_x = oe_x_q | ~r_wx;

`ifdef MON_BUS_TIMEOUT_EN
  logic [20:0] tcnt_q;
  logic        tmo_q;
  logic        in_high;

  assign in_high = (state_q == S_HIGH) || (state_q == S_QLO);
  assign tmo_hit = in_high && !emit && (tcnt_q == 21'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk_20mhz or negedge reset_x) begin
    if (!reset_x) begin
      tcnt_q <= '0;
      tmo_q  <= 1'b0;
    end else begin
      if (!in_high || emit || tmo_hit) tcnt_q <= '0;
      else                             tcnt_q <= tcnt_q + 1'b1;
      if (tmo_hit) tmo_q <= 1'b1;
    end
  end

  assign bus_timeout = tmo_q;
`else
  assign tmo_hit     = 1'b0;
  assign bus_timeout = 1'b0;
`endif
endmodule
